// File: rtl/multi_byte_add_seq_pkg.sv
// Shared definitions for the multi-slice add/subtract sequencer.
// The ALU decode imports this package too.
package multi_byte_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // The half-carry flag reports the carry out of bit 3, which is the carry into this bit.
    localparam int HALF_CARRY_BIT = 4;

endpackage

// File: rtl/multi_byte_add_seq_bit_adder.sv
// Plain DATA_WIDTH-bit ripple adder with carry in/out.
// The sequencer time-shares one instance of it.
module bit_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_carry_in,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_carry_out
);

    assign {o_carry_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DATA_WIDTH{1'b0}}, i_carry_in};

endmodule

// File: rtl/multi_byte_add_seq.sv
// Sequencer for a NUM_BYTES*DATA_WIDTH add/subtract. It processes one slice per cycle,
// LSB first, through a single shared bit_adder and produces C, H and Z flags.
module multi_byte_add_seq
    import multi_byte_add_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BYTES  = 2
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_start,
    input  logic                           i_sub,
    input  logic                           i_use_carry,
    input  logic                           i_carry_flag,
    input  logic [DATA_WIDTH*NUM_BYTES-1:0] i_op_a,
    input  logic [DATA_WIDTH*NUM_BYTES-1:0] i_op_b,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [DATA_WIDTH*NUM_BYTES-1:0] o_result,
    output logic                           o_carry,
    output logic                           o_half_carry,
    output logic                           o_zero
);

    localparam int TOTAL_W = DATA_WIDTH * NUM_BYTES;
    localparam int IDX_W   = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 carry_q, carry_d;
    logic                 sub_q, sub_d;
    logic [TOTAL_W-1:0]   op_a_q, op_a_d;
    logic [TOTAL_W-1:0]   op_b_q, op_b_d;
    logic [TOTAL_W-1:0]   acc_q, acc_d;
    logic [TOTAL_W-1:0]   result_q, result_d;
    logic                 flag_c_q, flag_c_d;
    logic                 flag_h_q, flag_h_d;
    logic                 flag_z_q, flag_z_d;

    logic [DATA_WIDTH-1:0] slice_a;
    logic [DATA_WIDTH-1:0] slice_b;
    logic [DATA_WIDTH-1:0] slice_sum;
    logic                  slice_cout;
    logic                  nibble_carry;
    logic                  incoming_carry;

    assign slice_a = op_a_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign slice_b = op_b_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] ^ {DATA_WIDTH{sub_q}};

    bit_adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_adder (
        .i_a         (slice_a),
        .i_b         (slice_b),
        .i_carry_in  (carry_q),
        .o_sum       (slice_sum),
        .o_carry_out (slice_cout)
    );

    // The carry into bit 4 equals sum ^ a ^ b at that bit. This matches bit 4 of the low-nibble sum.
    assign nibble_carry = slice_sum[HALF_CARRY_BIT] ^ slice_a[HALF_CARRY_BIT] ^ slice_b[HALF_CARRY_BIT];

    assign incoming_carry = i_use_carry & i_carry_flag;

    always_comb begin
        // NOTE: every signal gets its default first so no path can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        result_d = result_q;
        flag_c_d = flag_c_q;
        flag_h_d = flag_h_q;
        flag_z_d = flag_z_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (i_start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    sub_d   = i_sub;
                    op_a_d  = i_op_a;
                    op_b_d  = i_op_b;
                    // Subtraction is A + ~B + 1, and the +1 is dropped when a borrow comes in.
                    carry_d = i_sub ? ~incoming_carry : incoming_carry;
                end
            end
            ST_RUN: begin
                acc_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    state_d  = ST_DONE;
                    result_d = acc_d;
                    flag_c_d = slice_cout ^ sub_q;
                    flag_h_d = nibble_carry ^ sub_q;
                    flag_z_d = (acc_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: operand and accumulator registers are reset as well. A reset leaves no stale operation state behind.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_h_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_h_q <= flag_h_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign o_busy       = (state_q == ST_RUN);
    assign o_done       = (state_q == ST_DONE);
    assign o_result     = result_q;
    assign o_carry      = flag_c_q;
    assign o_half_carry = flag_h_q;
    assign o_zero       = flag_z_q;

endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Directed bench for multi_byte_add_seq (8x2). The expected values are hand-computed
// and cover reset, the handshake timing and the flag semantics.
module tb_multi_byte_add_seq;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_BYTES  = 2;
    localparam int TOTAL_W    = DATA_WIDTH * NUM_BYTES;

    logic               i_clk = 1'b0;
    logic               i_reset_n = 1'b0;
    logic               i_start = 1'b0;
    logic               i_sub = 1'b0;
    logic               i_use_carry = 1'b0;
    logic               i_carry_flag = 1'b0;
    logic [TOTAL_W-1:0] i_op_a = '0;
    logic [TOTAL_W-1:0] i_op_b = '0;
    logic               o_busy;
    logic               o_done;
    logic [TOTAL_W-1:0] o_result;
    logic               o_carry;
    logic               o_half_carry;
    logic               o_zero;

    int checks = 0;
    int errors = 0;
    logic [TOTAL_W-1:0] last_result = '0;

    multi_byte_add_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BYTES  (NUM_BYTES)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_sub        (i_sub),
        .i_use_carry  (i_use_carry),
        .i_carry_flag (i_carry_flag),
        .i_op_a       (i_op_a),
        .i_op_b       (i_op_b),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_carry      (o_carry),
        .o_half_carry (o_half_carry),
        .o_zero       (o_zero)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drive(input logic sub, input logic uc, input logic cf,
                         input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b);
        i_sub        = sub;
        i_use_carry  = uc;
        i_carry_flag = cf;
        i_op_a       = a;
        i_op_b       = b;
    endtask

    // The task is called at a negedge with the DUT idle. When poke is set, start is raised
    // with junk operands during RUN, and the DUT must ignore it.
    task automatic run_op(input string tag, input logic sub, input logic uc, input logic cf,
                          input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b,
                          input logic [TOTAL_W-1:0] exp_r, input logic exp_c,
                          input logic exp_h, input logic exp_z, input logic poke);
        drive(sub, uc, cf, a, b);
        i_start = 1'b1;
        step();
        if (poke) drive(~sub, 1'b1, 1'b1, ~a, a ^ b ^ 16'h5A5A);
        else i_start = 1'b0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            check({tag, "_busy"}, 32'(o_busy), 32'd1);
            check({tag, "_done_early"}, 32'(o_done), 32'd0);
            check({tag, "_hold"}, 32'(o_result), 32'(last_result));
            step();
        end
        i_start = 1'b0;
        check({tag, "_done"}, 32'(o_done), 32'd1);
        check({tag, "_busy_off"}, 32'(o_busy), 32'd0);
        check({tag, "_result"}, 32'(o_result), 32'(exp_r));
        check({tag, "_c"}, 32'(o_carry), 32'(exp_c));
        check({tag, "_h"}, 32'(o_half_carry), 32'(exp_h));
        check({tag, "_z"}, 32'(o_zero), 32'(exp_z));
        last_result = exp_r;
        step();
        check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        check({tag, "_idle_hold"}, 32'(o_result), 32'(exp_r));
    endtask

    typedef struct {
        logic               sub;
        logic [TOTAL_W-1:0] a;
        logic [TOTAL_W-1:0] b;
        logic [TOTAL_W-1:0] r;
        logic               c;
        logic               h;
        logic               z;
    } vec_t;

    vec_t b2b [3];

    initial begin
        // Reset state
        #12;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_flags", {29'd0, o_carry, o_half_carry, o_zero}, 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        step();

        // ADC 0x1234 + 0x1111 + 1 gives a nonzero result that the reset below must clear.
        run_op("adc", 1'b0, 1'b1, 1'b1, 16'h1234, 16'h1111, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted after the first slice
        drive(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        check("midrst_result", 32'(o_result), 32'd0);
        check("midrst_flags", {29'd0, o_carry, o_half_carry, o_zero}, 32'd0);
        step();
        i_reset_n = 1'b1;
        last_result = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_no_done", 32'(o_done), 32'd0);
            check("midrst_idle", 32'(o_busy), 32'd0);
        end

        // Directed ops
        run_op("add_wrap", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("sub", 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("adc2", 1'b0, 1'b1, 1'b1, 16'h1234, 16'h1111, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sbc", 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        // Carry flag that is not used must not feed the adder.
        run_op("add_nouc", 1'b0, 1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        // Start pulsed during RUN with different operands
        run_op("poke", 1'b0, 1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Back-to-back: start held high, operands change every cycle
        b2b[0] = '{sub: 1'b0, a: 16'h0FFF, b: 16'h0001, r: 16'h1000, c: 1'b0, h: 1'b1, z: 1'b0};
        b2b[1] = '{sub: 1'b1, a: 16'h5555, b: 16'h5555, r: 16'h0000, c: 1'b0, h: 1'b0, z: 1'b1};
        b2b[2] = '{sub: 1'b0, a: 16'h8000, b: 16'h8000, r: 16'h0000, c: 1'b1, h: 1'b0, z: 1'b1};
        i_start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) drive(b2b[c/3].sub, 1'b0, 1'b0, b2b[c/3].a, b2b[c/3].b);
            else drive(~b2b[c/3].sub, 1'b1, 1'b1, 16'hFFFF, 16'hF0F0 + 16'(c));
            step();
            check($sformatf("b2b%0d_busy", c), 32'(o_busy), 32'(c % 3 != 2));
            check($sformatf("b2b%0d_done", c), 32'(o_done), 32'(c % 3 == 2));
            if (c % 3 == 2) begin
                check($sformatf("b2b%0d_result", c), 32'(o_result), 32'(b2b[c/3].r));
                check($sformatf("b2b%0d_flags", c), {29'd0, o_carry, o_half_carry, o_zero},
                      {29'd0, b2b[c/3].c, b2b[c/3].h, b2b[c/3].z});
            end
        end
        i_start = 1'b0;
        step();
        check("b2b_end_done", 32'(o_done), 32'd0);
        check("b2b_end_busy", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
